// File: rtl/out_port_rr_arbiter.sv
// Purpose: per-output wormhole arbiter with rotating priority and a saturating completed-packet counter.
// Latency: request at cycle t gives a registered grant at t+1; the owner is released the cycle after its tail transfer.
// Backpressure: full or an owner bubble stalls the transfer; the lock is held until the tail flit actually moves.
module out_port_rr_arbiter #(
    parameter int N     = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     tail,
    input  logic             full,
    output logic [N-1:0]     arb_res,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_cnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N-1:0]       r_arb_res;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_pkt_cnt;

    logic               w_found;
    logic [PTR_W-1:0]   w_pick_idx;
    int                 w_scan;
    logic               w_xfer;
    logic               w_release;
    logic               w_grant;

    // Rotating search: first requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        w_found    = 1'b0;
        w_pick_idx = '0;
        w_scan     = 0;
        for (int k = 0; k < N; k++) begin
            w_scan = (int'(r_rr_ptr) + k) % N;
            if (!w_found && req[w_scan[PTR_W-1:0]]) begin
                w_found    = 1'b1;
                w_pick_idx = w_scan[PTR_W-1:0];
            end
        end
    end

    // Transfer only when the owner is requesting and downstream has room; tail only matters then.
    always_comb begin
        w_xfer    = (r_state == LOCKED) && (|(r_arb_res & req)) && !full;
        w_release = w_xfer && (|(r_arb_res & tail));
        w_grant   = (r_state == IDLE) && w_found;
    end

    // Next-state logic: IDLE locks onto a winner, LOCKED releases only on a tail transfer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant)   w_state_nxt = LOCKED;
            LOCKED:  if (w_release) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, grant, pointer and counter registers; reset wins over a same-cycle tail transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_arb_res <= '0;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_pkt_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_arb_res <= N'(1) << w_pick_idx;
                r_owner   <= w_pick_idx;
            end else if (w_release) begin
                r_arb_res <= '0;
                r_rr_ptr  <= (r_owner == PTR_W'(N - 1)) ? '0 : r_owner + 1'b1;
                if (r_pkt_cnt != {CNT_W{1'b1}}) begin
                    r_pkt_cnt <= r_pkt_cnt + 1'b1;
                end
            end
        end
    end

    // Outputs come straight from registers; no input reaches an output combinationally.
    always_comb begin
        arb_res = r_arb_res;
        busy    = (r_state == LOCKED);
        pkt_cnt = r_pkt_cnt;
    end

endmodule

// File: tb/tb_out_port_rr_arbiter.sv
// Purpose: directed and randomized self-checking bench for out_port_rr_arbiter (N=3, CNT_W=4).
// Latency: inputs are driven 1ns after a rising edge; outputs are sampled at the same point.
// Backpressure: full and requester bubbles are exercised directly against the wormhole lock.
module tb_out_port_rr_arbiter;

    localparam int N     = 3;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N-1:0]     tail;
    logic             full;
    logic [N-1:0]     arb_res;
    logic             busy;
    logic [CNT_W-1:0] pkt_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    out_port_rr_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .tail    (tail),
        .full    (full),
        .arb_res (arb_res),
        .busy    (busy),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [N-1:0] rq, input logic [N-1:0] tl, input logic fl);
        rst  = r;
        req  = rq;
        tail = tl;
        full = fl;
    endtask

    task automatic do_reset();
        drive(1'b1, '0, '0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    logic [N-1:0] seq_exp [7];
    logic [N-1:0] prev_arb, prev_req, prev_tail;
    logic         prev_full;
    logic         tail_xfer;
    int           miss [N];

    initial begin
        drive(1'b0, '0, '0, 1'b0);

        // Single-flit packet from S, then rotation check.
        do_reset();
        chk("rst_arb", arb_res, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", pkt_cnt, 0);
        drive(1'b0, 3'b001, 3'b001, 1'b0);
        tick();
        chk("t1_grant", arb_res, 3'b001);
        chk("t1_busy", busy, 1'b1);
        tick();
        chk("t1_release", arb_res, 3'b000);
        chk("t1_cnt", pkt_cnt, 1);
        chk("t1_idle", busy, 1'b0);
        drive(1'b0, 3'b111, 3'b000, 1'b0);
        tick();
        chk("t1_ptr1", arb_res, 3'b010);

        // All three requesting single-flit packets: round-robin with bubbles.
        seq_exp = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
        drive(1'b1, 3'b111, 3'b111, 1'b0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            tick();
            chk($sformatf("rr_seq%0d", c), arb_res, seq_exp[c]);
            chk($sformatf("rr_busy%0d", c), busy, |seq_exp[c]);
            if (c == 5) chk("rr_cnt3", pkt_cnt, 3);
        end

        // 4-flit packet on E with backpressure and an owner bubble; L and S ignored.
        do_reset();
        drive(1'b0, 3'b010, 3'b000, 1'b0);
        tick();
        chk("e_grant", arb_res, 3'b010);
        drive(1'b0, 3'b111, 3'b101, 1'b0);  tick(); chk("e_f1", arb_res, 3'b010);
        drive(1'b0, 3'b111, 3'b111, 1'b1);  tick(); chk("e_full0", arb_res, 3'b010);
        tick(); chk("e_full1", arb_res, 3'b010);
        tick(); chk("e_full2", arb_res, 3'b010);
        drive(1'b0, 3'b111, 3'b101, 1'b0);  tick(); chk("e_f2", arb_res, 3'b010);
        drive(1'b0, 3'b101, 3'b111, 1'b0);  tick(); chk("e_bubble", arb_res, 3'b010);
        drive(1'b0, 3'b111, 3'b101, 1'b0);  tick(); chk("e_f3", arb_res, 3'b010);
        chk("e_cnt_mid", pkt_cnt, 0);
        drive(1'b0, 3'b111, 3'b010, 1'b0);  tick(); chk("e_release", arb_res, 3'b000);
        chk("e_cnt", pkt_cnt, 1);
        drive(1'b0, 3'b111, 3'b000, 1'b0);  tick(); chk("e_next_L", arb_res, 3'b100);

        // Reset during a locked L packet, coincident with its tail transfer.
        do_reset();
        drive(1'b0, 3'b100, 3'b000, 1'b0);
        tick(); chk("r_grant", arb_res, 3'b100);
        tick(); chk("r_hold", arb_res, 3'b100);
        drive(1'b1, 3'b100, 3'b100, 1'b0);
        tick();
        chk("r_arb", arb_res, 3'b000);
        chk("r_busy", busy, 1'b0);
        chk("r_cnt", pkt_cnt, 0);
        drive(1'b0, 3'b110, 3'b000, 1'b0);
        tick(); chk("r_regrant", arb_res, 3'b010);

        // Counter saturation at 4'hF.
        do_reset();
        drive(1'b0, 3'b001, 3'b001, 1'b0);
        for (int p = 0; p < 15; p++) begin
            tick();
            tick();
        end
        chk("sat_15", pkt_cnt, 4'hF);
        tick(); chk("sat_grant", arb_res, 3'b001);
        tick(); chk("sat_hold", pkt_cnt, 4'hF);
        chk("sat_idle", arb_res, 3'b000);

        // Randomized invariant and fairness checking.
        do_reset();
        for (int i = 0; i < N; i++) miss[i] = 0;
        drive(1'b0, 3'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0));
        prev_arb = arb_res; prev_req = req; prev_tail = tail; prev_full = full;
        for (int c = 0; c < 10000; c++) begin
            tick();
            chk("rnd_onehot", $onehot0(arb_res), 1'b1);
            chk("rnd_busy", busy, |arb_res);
            tail_xfer = (|(prev_arb & prev_req & prev_tail)) && !prev_full;
            if (prev_arb != 0) begin
                chk("rnd_lock", arb_res, tail_xfer ? 3'b000 : prev_arb);
            end else if (prev_req == 0) begin
                chk("rnd_idle", arb_res, 3'b000);
            end else begin
                chk("rnd_pick_req", |(arb_res & prev_req), 1'b1);
                for (int i = 0; i < N; i++) begin
                    if (arb_res[i] || !prev_req[i]) miss[i] = 0;
                    else miss[i]++;
                    chk($sformatf("rnd_starve%0d", i), miss[i] <= N - 1, 1'b1);
                end
            end
            prev_arb = arb_res;
            drive(1'b0,
                  {($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8)},
                  3'($urandom), ($urandom_range(0, 3) == 0));
            prev_req = req; prev_tail = tail; prev_full = full;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
